// File: rtl/stage_3_pkg.sv
// Shared definitions for the carry-resolution output stage: FSM states, the
// deferrable 0xFF word and default widths shared with the upstream stage.
package stage_3_pkg;

  localparam int DEF_OUT_WIDTH      = 8;
  localparam int DEF_PRECARRY_WIDTH = 9;
  localparam int DEF_RUN_WIDTH      = 16;

  localparam logic [8:0] BYTE_FF = 9'h0FF;

  typedef enum logic [2:0] {
    EMPTY,
    HOLD,
    EMIT_PEND,
    EMIT_RUN,
    FINISH
  } state_t;

endpackage

// File: rtl/stage_3.sv
// Final encoder stage: holds one pending byte plus a run of deferred 0xFF bytes,
// resolves them once a carry decision arrives, and streams finished bytes out.
module stage_3
  import stage_3_pkg::*;
#(
  parameter int OUT_WIDTH      = DEF_OUT_WIDTH,
  parameter int PRECARRY_WIDTH = DEF_PRECARRY_WIDTH,
  parameter int RUN_WIDTH      = DEF_RUN_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [PRECARRY_WIDTH-1:0] in_data,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_WIDTH-1:0]      out_byte,
  output logic                      done,
  output logic                      run_ovf
);

  localparam logic [RUN_WIDTH-1:0]      RUN_MAX = '1;
  localparam logic [RUN_WIDTH-1:0]      RUN_ONE = RUN_WIDTH'(1);
  localparam logic [PRECARRY_WIDTH-1:0] WORD_FF = PRECARRY_WIDTH'(BYTE_FF);

  state_t                r_state, w_state;
  logic [OUT_WIDTH-1:0]  r_pending, w_pending;
  logic [OUT_WIDTH-1:0]  r_outByte, w_outByte;
  logic [RUN_WIDTH-1:0]  r_run, w_run;
  logic                  r_carryQ, w_carryQ;
  logic                  r_outValid, w_outValid;
  logic                  r_done, w_done;
  logic                  r_runOvf, w_runOvf;
  logic                  r_flush, w_flush;
  logic                  r_final, w_final;

  logic                  w_accept;
  logic                  w_handshake;
  logic                  w_release;
  logic                  w_carry;
  logic [OUT_WIDTH-1:0]  w_byte;
  logic [OUT_WIDTH-1:0]  w_runByte;

  assign in_ready    = ((r_state == EMPTY) || (r_state == HOLD)) && !r_outValid;
  assign w_accept    = in_valid && in_ready;
  assign w_handshake = r_outValid && out_ready;
  assign w_carry     = in_data[PRECARRY_WIDTH-1];
  assign w_byte      = in_data[OUT_WIDTH-1:0];
  assign w_runByte   = r_carryQ ? '0 : '1;

  always_comb begin
    w_state    = r_state;
    w_pending  = r_pending;
    w_outByte  = r_outByte;
    w_run      = r_run;
    w_carryQ   = r_carryQ;
    w_outValid = r_outValid;
    w_done     = 1'b0;
    w_runOvf   = r_runOvf;
    w_flush    = r_flush;
    w_final    = r_final;
    w_release  = 1'b0;

    case (r_state)
      EMPTY: begin
        if (w_accept) begin
          w_pending = w_byte;
          w_state   = HOLD;
          if (in_last) begin
            w_outByte  = w_byte;
            w_outValid = 1'b1;
            w_carryQ   = 1'b0;
            w_flush    = 1'b1;
            w_final    = 1'b1;
            w_state    = EMIT_PEND;
          end
        end
      end
      HOLD: begin
        if (w_accept) begin
          if (in_data == WORD_FF) begin
            if (r_run == RUN_MAX) w_runOvf = 1'b1;
            else                  w_run    = r_run + 1'b1;
            // A final 0xFF word flushes pending plus the run with no carry.
            if (in_last) begin
              w_outByte  = r_pending;
              w_outValid = 1'b1;
              w_carryQ   = 1'b0;
              w_flush    = 1'b1;
              w_final    = 1'b1;
              w_state    = EMIT_PEND;
            end
          end else begin
            w_outByte  = r_pending + {{(OUT_WIDTH-1){1'b0}}, w_carry};
            w_carryQ   = w_carry;
            w_pending  = w_byte;
            w_outValid = 1'b1;
            w_flush    = in_last;
            w_final    = 1'b0;
            w_state    = EMIT_PEND;
          end
        end
      end
      EMIT_PEND: begin
        if (w_handshake) begin
          if (r_run != '0) begin
            w_outByte = w_runByte;
            w_state   = EMIT_RUN;
          end else begin
            w_release = 1'b1;
          end
        end
      end
      EMIT_RUN: begin
        if (w_handshake) begin
          w_run = r_run - 1'b1;
          if (r_run == RUN_ONE) w_release = 1'b1;
        end
      end
      FINISH:  w_state = EMPTY;
      default: w_state = EMPTY;
    endcase

    // End of a burst: either idle in HOLD, emit the flushed pending byte, or close the frame.
    if (w_release) begin
      if (!r_flush) begin
        w_outValid = 1'b0;
        w_state    = HOLD;
      end else if (!r_final) begin
        w_outByte = r_pending;
        w_carryQ  = 1'b0;
        w_final   = 1'b1;
        w_state   = EMIT_PEND;
      end else begin
        w_outValid = 1'b0;
        w_flush    = 1'b0;
        w_final    = 1'b0;
        w_pending  = '0;
        w_done     = 1'b1;
        w_state    = FINISH;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= EMPTY;
      r_pending  <= '0;
      r_outByte  <= '0;
      r_run      <= '0;
      r_carryQ   <= 1'b0;
      r_outValid <= 1'b0;
      r_done     <= 1'b0;
      r_runOvf   <= 1'b0;
      r_flush    <= 1'b0;
      r_final    <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_pending  <= w_pending;
      r_outByte  <= w_outByte;
      r_run      <= w_run;
      r_carryQ   <= w_carryQ;
      r_outValid <= w_outValid;
      r_done     <= w_done;
      r_runOvf   <= w_runOvf;
      r_flush    <= w_flush;
      r_final    <= w_final;
    end
  end

  assign out_valid = r_outValid;
  assign out_byte  = r_outByte;
  assign done      = r_done;
  assign run_ovf   = r_runOvf;

endmodule

// File: tb/tb_stage_3.sv
// Bench for stage_3: a stream-level byte model predicts every emitted byte and
// done pulse, plus directed literal scenarios and a narrow-counter overflow case.
module tb_stage_3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_last;
  logic [8:0] in_data;
  logic       out_ready;
  logic       in_ready, out_valid, done, run_ovf;
  logic [7:0] out_byte;

  logic       ovValid, ovLast;
  logic [8:0] ovData;
  logic       ovReady;
  logic       ovInReady, ovOutValid, ovDone, ovOvf;
  logic [7:0] ovOutByte;

  int assertCount = 0;
  int failCount   = 0;

  logic randReady = 1'b0;
  logic forcedReady = 1'b1;
  logic rndBit = 1'b1;

  logic [7:0] expQ[$];
  bit         lastQ[$];
  logic [7:0] gotBytes[$];
  logic [7:0] mPending;
  bit         mHave;
  int         mRun;
  bit         doneDue;
  bit         prevStall;
  logic [7:0] prevByte;
  int         doneCount = 0;

  stage_3 dut (
    .clk(clk), .reset(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
    .done(done), .run_ovf(run_ovf)
  );

  stage_3 #(.RUN_WIDTH(2)) u_ovf (
    .clk(clk), .reset(rst_n),
    .in_valid(ovValid), .in_ready(ovInReady), .in_data(ovData), .in_last(ovLast),
    .out_valid(ovOutValid), .out_ready(ovReady), .out_byte(ovOutByte),
    .done(ovDone), .run_ovf(ovOvf)
  );

  always #5 clk = ~clk;

  always_comb out_ready = randReady ? rndBit : forcedReady;

  always @(posedge clk) begin
    #1;
    rndBit = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkBit(input string name, input logic got, input logic exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0b, expected %0b", name, got, exp);
    end
  endtask

  task automatic checkByte(input string name, input logic [7:0] got, input logic [7:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, got, exp);
    end
  endtask

  task automatic checkStream(input string name, input int n,
                             input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
    logic [7:0] e[4];
    e = '{b0, b1, b2, b3};
    checkByte({name, "_len"}, 8'(gotBytes.size()), 8'(n));
    for (int i = 0; i < n; i++)
      checkByte($sformatf("%s_b%0d", name, i),
                (i < gotBytes.size()) ? gotBytes[i] : ~e[i], e[i]);
  endtask

  // Stream-level model: what bytes a frame must produce, independent of timing.
  task automatic modelAccept(input logic [8:0] v, input logic last);
    logic [7:0] b = v[7:0];
    logic       c = v[8];
    if (!mHave) begin
      mPending = b;
      mHave    = 1'b1;
    end else if (v == 9'h0FF) begin
      mRun++;
    end else begin
      expQ.push_back(mPending + {7'd0, c}); lastQ.push_back(1'b0);
      for (int i = 0; i < mRun; i++) begin
        expQ.push_back(c ? 8'h00 : 8'hFF); lastQ.push_back(1'b0);
      end
      mRun     = 0;
      mPending = b;
    end
    if (last) begin
      expQ.push_back(mPending); lastQ.push_back(1'b0);
      for (int i = 0; i < mRun; i++) begin
        expQ.push_back(8'hFF); lastQ.push_back(1'b0);
      end
      lastQ[lastQ.size()-1] = 1'b1;
      mRun  = 0;
      mHave = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    bit expInReady;
    if (!rst_n) begin
      checkBit("rst_out_valid", out_valid, 1'b0);
      checkByte("rst_out_byte", out_byte, 8'h00);
      checkBit("rst_in_ready", in_ready, 1'b1);
      checkBit("rst_done", done, 1'b0);
      checkBit("rst_run_ovf", run_ovf, 1'b0);
      expQ.delete(); lastQ.delete();
      mPending = 8'h00; mHave = 1'b0; mRun = 0;
      doneDue = 1'b0; prevStall = 1'b0;
    end else begin
      expInReady = (expQ.size() == 0) && !doneDue;
      checkBit("done", done, doneDue);
      checkBit("in_ready", in_ready, expInReady);
      checkBit("out_valid", out_valid, expQ.size() != 0);
      checkBit("run_ovf", run_ovf, 1'b0);
      if (expQ.size() != 0) checkByte("out_byte", out_byte, expQ[0]);
      if (prevStall) begin
        checkBit("stall_valid", out_valid, 1'b1);
        checkByte("stall_byte", out_byte, prevByte);
      end
      if (done) doneCount++;
      doneDue   = 1'b0;
      prevStall = out_valid && !out_ready;
      prevByte  = out_byte;
      if (expQ.size() != 0 && out_ready) begin
        gotBytes.push_back(out_byte);
        doneDue = lastQ[0];
        void'(expQ.pop_front());
        void'(lastQ.pop_front());
      end
      if (in_valid && expInReady) modelAccept(in_data, in_last);
    end
  end

  task automatic applyStimulus(input logic [8:0] w, input logic last);
    int n = 0;
    in_valid = 1'b1;
    in_data  = w;
    in_last  = last;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      assertCount++; failCount++;
      $display("[TB] FAIL accept_timeout: got in_ready=0 for 200 cycles, expected acceptance");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (!(expQ.size() == 0 && !doneDue && in_ready) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 500) begin
      assertCount++; failCount++;
      $display("[TB] FAIL idle_timeout: got busy for 500 cycles, expected drain");
    end
  endtask

  initial begin
    int d0;
    int nWords;
    int ovDoneCnt;
    logic [8:0] w;
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 9'h000;
    ovValid = 1'b0; ovLast = 1'b0; ovData = 9'h000; ovReady = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    gotBytes.delete(); d0 = doneCount;
    applyStimulus(9'h012, 1'b0);
    applyStimulus(9'h034, 1'b1);
    waitIdle();
    checkStream("t2", 2, 8'h12, 8'h34, 8'h00, 8'h00);
    checkByte("t2_done_pulses", 8'(doneCount - d0), 8'd1);

    gotBytes.delete();
    applyStimulus(9'h012, 1'b0);
    applyStimulus(9'h0FF, 1'b0);
    applyStimulus(9'h0FF, 1'b0);
    applyStimulus(9'h105, 1'b0);
    waitIdle();
    checkStream("t3a", 3, 8'h13, 8'h00, 8'h00, 8'h00);
    gotBytes.delete(); d0 = doneCount;
    applyStimulus(9'h000, 1'b1);
    waitIdle();
    checkStream("t3b", 2, 8'h05, 8'h00, 8'h00, 8'h00);
    checkByte("t3_done_pulses", 8'(doneCount - d0), 8'd1);

    gotBytes.delete();
    applyStimulus(9'h012, 1'b0);
    applyStimulus(9'h0FF, 1'b0);
    applyStimulus(9'h040, 1'b0);
    waitIdle();
    checkStream("t4", 2, 8'h12, 8'hFF, 8'h00, 8'h00);
    checkBit("t4_in_ready", in_ready, 1'b1);
    gotBytes.delete();
    applyStimulus(9'h000, 1'b1);
    waitIdle();
    checkStream("t4_close", 2, 8'h40, 8'h00, 8'h00, 8'h00);

    gotBytes.delete();
    applyStimulus(9'h012, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(9'h0FF, 1'b0);
    applyStimulus(9'h100, 1'b0);
    @(posedge clk); @(posedge clk); #1 forcedReady = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checkByte("t5_stall_byte", out_byte, 8'h00);
      checkBit("t5_stall_valid", out_valid, 1'b1);
      checkBit("t5_stall_in_ready", in_ready, 1'b0);
    end
    @(posedge clk); #1 forcedReady = 1'b1;
    waitIdle();
    checkStream("t5", 4, 8'h13, 8'h00, 8'h00, 8'h00);
    gotBytes.delete();
    applyStimulus(9'h000, 1'b1);
    waitIdle();
    checkStream("t5_close", 2, 8'h00, 8'h00, 8'h00, 8'h00);

    gotBytes.delete();
    forcedReady = 1'b0;
    applyStimulus(9'h012, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(9'h0FF, 1'b0);
    applyStimulus(9'h105, 1'b0);
    forcedReady = 1'b1;
    @(posedge clk); #1 forcedReady = 1'b0;
    @(negedge clk);
    checkByte("t1_run_byte", out_byte, 8'h00);
    checkBit("t1_run_valid", out_valid, 1'b1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    checkBit("t1_out_valid", out_valid, 1'b0);
    checkBit("t1_in_ready", in_ready, 1'b1);
    checkBit("t1_done", done, 1'b0);
    checkBit("t1_run_ovf", run_ovf, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; forcedReady = 1'b1;
    checkStream("t1", 1, 8'h13, 8'h00, 8'h00, 8'h00);

    ovValid = 1'b1; ovData = 9'h012;
    @(posedge clk); #1 ovData = 9'h0FF;
    repeat (3) begin @(posedge clk); #1; end
    ovValid = 1'b0;
    @(negedge clk);
    checkBit("t6_no_ovf_at_max", ovOvf, 1'b0);
    @(posedge clk); #1 ovValid = 1'b1;
    @(posedge clk); #1 ovValid = 1'b0;
    @(negedge clk);
    checkBit("t6_ovf_set", ovOvf, 1'b1);
    repeat (5) @(posedge clk);
    #1 ovValid = 1'b1; ovData = 9'h000; ovLast = 1'b1;
    @(posedge clk); #1 ovValid = 1'b0; ovLast = 1'b0;
    @(negedge clk);
    checkBit("t6_first_valid", ovOutValid, 1'b1);
    checkByte("t6_first_byte", ovOutByte, 8'h12);
    ovDoneCnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (ovDone) ovDoneCnt++;
    end
    checkByte("t6_done_pulses", 8'(ovDoneCnt), 8'd1);
    checkBit("t6_ovf_sticky", ovOvf, 1'b1);
    checkBit("t6_in_ready", ovInReady, 1'b1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    checkBit("t6_ovf_cleared", ovOvf, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;

    randReady = 1'b1;
    for (int f = 0; f < 40; f++) begin
      nWords = $urandom_range(1, 8);
      for (int k = 0; k < nWords; k++) begin
        w = ($urandom_range(0, 3) == 0) ? 9'h0FF : 9'($urandom);
        applyStimulus(w, k == nWords - 1);
        if ($urandom_range(0, 3) == 0) begin
          in_last = 1'($urandom_range(0, 1));
          repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
          in_last = 1'b0;
        end
      end
    end
    waitIdle();
    randReady = 1'b0;
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
